// File: rtl/slowfil_sched_pkg.sv
// Shared state encodings and default sizes for the slowfil scheduler and the
// filter it drives.
package slowfil_sched_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int DEF_LGNTAPS = 7;
    localparam int DEF_NTAPS   = 110;
    localparam int DEF_IW      = 16;
    localparam int DEF_TW      = 16;

endpackage

// File: rtl/slowfil_pacer.sv
// Gap counter: loads on a sample accept, counts down to zero and holds there.
// The zero flag is what opens the sample port again.
module slowfil_pacer #(
    parameter int          GW       = 3,
    parameter int unsigned LOAD_VAL = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_load,
    output logic o_zero
);

    logic [GW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= GW'(LOAD_VAL);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/slowfil_sched.sv
// Sequencer in front of a slow serial FIR: resets it, streams in its taps,
// then paces samples so the filter always has a full idle gap between them.
module slowfil_sched
    import slowfil_sched_pkg::*;
#(
    parameter int LGNTAPS    = DEF_LGNTAPS,
    parameter int NTAPS      = DEF_NTAPS,
    parameter int IW         = DEF_IW,
    parameter int TW         = DEF_TW,
    parameter bit FIXED_TAPS = 1'b0,
    parameter int GAP_EXTRA  = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_reload,
    input  logic          i_tap_valid,
    output logic          o_tap_ready,
    input  logic [TW-1:0] i_tap,
    input  logic          i_sample_valid,
    output logic          o_sample_ready,
    input  logic [IW-1:0] i_sample,
    output logic          o_fil_reset,
    output logic          o_fil_tap_wr,
    output logic [TW-1:0] o_fil_tap,
    output logic          o_fil_ce,
    output logic [IW-1:0] o_fil_sample,
    output logic          o_loaded,
    output logic          o_busy
);

    localparam int               GW       = $clog2(NTAPS + GAP_EXTRA + 1);
    localparam logic [LGNTAPS:0] LAST_TAP = (LGNTAPS + 1)'(NTAPS - 1);

    state_t           r_state;
    logic             r_reload_pend;
    logic [LGNTAPS:0] r_tap_cnt;
    logic             w_tap_acc;
    logic             w_smp_acc;
    logic             w_gap_zero;

    // Ready flags decode registers only, so no input reaches them combinationally.
    assign o_tap_ready    = !FIXED_TAPS && (r_state == ST_LOAD);
    assign o_sample_ready = (r_state == ST_RUN) && w_gap_zero && !r_reload_pend;
    assign o_loaded       = (r_state == ST_RUN);
    assign o_busy         = !w_gap_zero || o_fil_ce;

    assign w_tap_acc = i_tap_valid && o_tap_ready;
    assign w_smp_acc = i_sample_valid && o_sample_ready;

    slowfil_pacer #(
        .GW       (GW),
        .LOAD_VAL (NTAPS + GAP_EXTRA)
    ) u_pacer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (r_state == ST_CLEAR),
        .i_load  (w_smp_acc),
        .o_zero  (w_gap_zero)
    );

    // NOTE: all state uses non-blocking assignments and the async reset branch
    // covers every register, so outputs change on reset with no clock edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_CLEAR;
            r_reload_pend <= 1'b0;
            r_tap_cnt     <= '0;
            o_fil_reset   <= 1'b1;
            o_fil_tap_wr  <= 1'b0;
            o_fil_tap     <= '0;
            o_fil_ce      <= 1'b0;
            o_fil_sample  <= '0;
        end else begin
            o_fil_tap_wr <= w_tap_acc;
            o_fil_ce     <= w_smp_acc;
            if (w_tap_acc) o_fil_tap    <= i_tap;
            if (w_smp_acc) o_fil_sample <= i_sample;

            case (r_state)
                ST_CLEAR: begin
                    r_tap_cnt     <= '0;
                    r_reload_pend <= 1'b0;
                    // Entered with reset low only when a last tap write was
                    // still draining; pulse the filter reset after it.
                    if (!o_fil_reset) begin
                        o_fil_reset <= 1'b1;
                    end else begin
                        o_fil_reset <= 1'b0;
                        r_state     <= FIXED_TAPS ? ST_RUN : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_tap_acc) r_tap_cnt <= r_tap_cnt + 1'b1;
                    if (i_reload) begin
                        r_state     <= ST_CLEAR;
                        o_fil_reset <= !w_tap_acc;
                    end else if (w_tap_acc && r_tap_cnt == LAST_TAP) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_reload) r_reload_pend <= 1'b1;
                    if (r_reload_pend && w_gap_zero) begin
                        r_state     <= ST_CLEAR;
                        o_fil_reset <= 1'b1;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_slowfil_sched.sv
// Directed bench for slowfil_sched: NTAPS=4 instance for the sequenced cases,
// a GAP_EXTRA=2 instance for randomly throttled streams.
module tb_slowfil_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_reload, a_tv, a_sv;
    logic [15:0] a_tap, a_smp;
    logic        a_tr, a_sr, a_fr, a_tw, a_ce, a_ld, a_busy;
    logic [15:0] a_ftap, a_fsmp;

    logic        b_rst, b_reload, b_tv, b_sv;
    logic [15:0] b_tap, b_smp;
    logic        b_tr, b_sr, b_fr, b_tw, b_ce, b_ld, b_busy;
    logic [15:0] b_ftap, b_fsmp;

    slowfil_sched #(.LGNTAPS(2), .NTAPS(4), .IW(16), .TW(16), .FIXED_TAPS(1'b0), .GAP_EXTRA(0)) u_dut_a (
        .i_clk(clk), .i_reset(a_rst), .i_reload(a_reload),
        .i_tap_valid(a_tv), .o_tap_ready(a_tr), .i_tap(a_tap),
        .i_sample_valid(a_sv), .o_sample_ready(a_sr), .i_sample(a_smp),
        .o_fil_reset(a_fr), .o_fil_tap_wr(a_tw), .o_fil_tap(a_ftap),
        .o_fil_ce(a_ce), .o_fil_sample(a_fsmp), .o_loaded(a_ld), .o_busy(a_busy)
    );

    slowfil_sched #(.LGNTAPS(2), .NTAPS(4), .IW(16), .TW(16), .FIXED_TAPS(1'b0), .GAP_EXTRA(2)) u_dut_b (
        .i_clk(clk), .i_reset(b_rst), .i_reload(b_reload),
        .i_tap_valid(b_tv), .o_tap_ready(b_tr), .i_tap(b_tap),
        .i_sample_valid(b_sv), .o_sample_ready(b_sr), .i_sample(b_smp),
        .o_fil_reset(b_fr), .o_fil_tap_wr(b_tw), .o_fil_tap(b_ftap),
        .o_fil_ce(b_ce), .o_fil_sample(b_fsmp), .o_loaded(b_ld), .o_busy(b_busy)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  saw_ce;
        int  next_tap, next_smp, wr_cnt, ce_cnt, last_ce;
        bit  tap_acc, smp_acc;

        a_rst = 1'b1; a_reload = 1'b0; a_tv = 1'b0; a_sv = 1'b0; a_tap = '0; a_smp = '0;
        b_rst = 1'b1; b_reload = 1'b0; b_tv = 1'b0; b_sv = 1'b0; b_tap = '0; b_smp = '0;

        // Reset values, before any clock edge
        #1;
        check("rst_fil_reset", 32'(a_fr), 32'd1);
        check("rst_loaded",    32'(a_ld), 32'd0);
        check("rst_tap_ready", 32'(a_tr), 32'd0);
        check("rst_smp_ready", 32'(a_sr), 32'd0);
        check("rst_ce",        32'(a_ce), 32'd0);
        check("rst_tap_wr",    32'(a_tw), 32'd0);
        check("rst_busy",      32'(a_busy), 32'd0);
        check("rst_fil_tap",   32'(a_ftap), 32'd0);
        check("rst_fil_smp",   32'(a_fsmp), 32'd0);
        step; step;
        check("rst_held_fil_reset", 32'(a_fr), 32'd1);
        a_rst = 1'b0;
        check("post_rst_fil_reset", 32'(a_fr), 32'd1);
        step;
        check("clear_exit_fil_reset", 32'(a_fr), 32'd0);
        check("load_tap_ready",       32'(a_tr), 32'd1);
        check("load_smp_ready",       32'(a_sr), 32'd0);

        // 1: four back-to-back taps
        a_tv = 1'b1; a_tap = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            step;
            check("t1_tap_wr",  32'(a_tw),   32'd1);
            check("t1_tap_val", 32'(a_ftap), 32'(i + 1));
            check("t1_fil_reset", 32'(a_fr), 32'd0);
            if (i < 3) a_tap = 16'(i + 2);
            else       a_tv = 1'b0;
        end
        check("t1_tap_ready_low", 32'(a_tr), 32'd0);
        check("t1_loaded",        32'(a_ld), 32'd1);

        // 2: two samples, 5 cycles between o_fil_ce pulses
        check("t2_smp_ready", 32'(a_sr), 32'd1);
        a_sv = 1'b1; a_smp = 16'h1234;
        step;
        check("t2_ce1",     32'(a_ce),   32'd1);
        check("t2_tap_wr",  32'(a_tw),   32'd0);
        check("t2_smp1",    32'(a_fsmp), 32'h1234);
        check("t2_busy",    32'(a_busy), 32'd1);
        check("t2_ready_low", 32'(a_sr), 32'd0);
        a_smp = 16'h5678;
        n = 0;
        do begin step; n++; end while (!a_ce && n < 20);
        check("t2_spacing", 32'(n), 32'd5);
        check("t2_smp2",    32'(a_fsmp), 32'h5678);

        // 3: reload 2 cycles after an accept, valid kept high
        a_smp = 16'h9999;
        step; step;
        a_reload = 1'b1;
        step;
        a_reload = 1'b0;
        check("t3_pend_ready_low", 32'(a_sr), 32'd0);
        n = 0; saw_ce = 1'b0;
        do begin step; n++; if (a_ce) saw_ce = 1'b1; end while (!a_fr && n < 20);
        check("t3_clear_delay", 32'(n), 32'd2);
        check("t3_no_accept",   32'(saw_ce), 32'd0);
        check("t3_loaded_low",  32'(a_ld), 32'd0);
        check("t3_gap_idle",    32'(a_busy), 32'd0);
        a_sv = 1'b0;
        step;
        check("t3_fil_reset_1cyc", 32'(a_fr), 32'd0);
        check("t3_tap_ready",      32'(a_tr), 32'd1);

        // 4: reload coincident with the 2nd of 4 taps, then a fresh load
        a_tv = 1'b1; a_tap = 16'h0010;
        step;
        check("t4_tap_wr0", 32'(a_tw), 32'd1);
        a_tap = 16'h0011; a_reload = 1'b1;
        step;
        check("t4_wr_with_reload", 32'(a_tw),   32'd1);
        check("t4_wr_val",         32'(a_ftap), 32'h0011);
        check("t4_no_reset_w_wr",  32'(a_fr),   32'd0);
        check("t4_tap_ready_low",  32'(a_tr),   32'd0);
        a_tv = 1'b0; a_reload = 1'b0;
        step;
        check("t4_fil_reset", 32'(a_fr), 32'd1);
        check("t4_wr_done",   32'(a_tw), 32'd0);
        step;
        check("t4_reset_end", 32'(a_fr), 32'd0);
        check("t4_reload_ready", 32'(a_tr), 32'd1);
        a_tv = 1'b1; a_tap = 16'h000A;
        for (int i = 0; i < 4; i++) begin
            step;
            check("t4_tap_wr",  32'(a_tw),   32'd1);
            check("t4_tap_val", 32'(a_ftap), 32'(16'h000A + i));
            check("t4_loaded",  32'(a_ld),   (i == 3) ? 32'd1 : 32'd0);
            if (i < 3) a_tap = 16'(16'h000B + i);
            else       a_tv = 1'b0;
        end

        // 5: async reset between edges, during a filter ce cycle
        a_sv = 1'b1; a_smp = 16'h4321;
        step;
        check("t5_ce_before", 32'(a_ce), 32'd1);
        a_sv = 1'b0;
        #2 a_rst = 1'b1;
        #1;
        check("t5_ce",        32'(a_ce), 32'd0);
        check("t5_loaded",    32'(a_ld), 32'd0);
        check("t5_fil_reset", 32'(a_fr), 32'd1);
        check("t5_busy",      32'(a_busy), 32'd0);
        step;
        a_rst = 1'b0;
        step;
        check("t5_recover_ready", 32'(a_tr), 32'd1);

        // 6: GAP_EXTRA=2, randomly throttled taps and samples
        b_rst = 1'b0;
        next_tap = 0; next_smp = 0; wr_cnt = 0; ce_cnt = 0; last_ce = -100;
        for (int cyc = 0; cyc < 220; cyc++) begin
            if (!b_tv && next_tap < 4 && $urandom_range(0, 2) != 0) begin
                b_tv = 1'b1; b_tap = 16'(16'h00B0 + next_tap);
            end
            if (!b_sv && next_smp < 12 && $urandom_range(0, 2) != 0) begin
                b_sv = 1'b1; b_smp = 16'(16'h0100 + next_smp);
            end
            if (!b_ld) check("t6_no_smp_before_load", 32'(b_sr), 32'd0);
            if (b_ld)  check("t6_no_tap_in_run",      32'(b_tr), 32'd0);
            tap_acc = b_tv && b_tr;
            smp_acc = b_sv && b_sr;
            step;
            if (tap_acc) begin next_tap++; b_tv = 1'b0; end
            if (smp_acc) begin next_smp++; b_sv = 1'b0; end
            check("t6_wr_follows_acc", 32'(b_tw), 32'(tap_acc));
            check("t6_ce_follows_acc", 32'(b_ce), 32'(smp_acc));
            if (b_tw) begin
                check("t6_tap_order", 32'(b_ftap), 32'(16'h00B0 + wr_cnt));
                wr_cnt++;
            end
            if (b_ce) begin
                check("t6_smp_order", 32'(b_fsmp), 32'(16'h0100 + ce_cnt));
                if (ce_cnt > 0) check("t6_min_gap", 32'((cyc - last_ce) >= 7), 32'd1);
                last_ce = cyc;
                ce_cnt++;
            end
        end
        check("t6_taps_written", 32'(wr_cnt), 32'd4);
        check("t6_samples_out",  32'(ce_cnt), 32'd12);
        check("t6_loaded",       32'(b_ld),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
